// File: rtl/vga_sprite_pkg.sv
// Shared types and default 640x480 timing constants for the VGA sprite compositor.
package vga_sprite_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int COORD_W = 10;
  localparam int BGR_W   = 24;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   diff_t;
  typedef logic [BGR_W-1:0]   bgr_t;

  localparam bgr_t KEY_BGR_DEF = 24'hFF00FF;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  // Offset of a beam coordinate from a sprite origin; negative offsets wrap to large values.
  function automatic diff_t coord_diff(input coord_t beam, input coord_t origin);
    return {1'b0, beam} - {1'b0, origin};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical beam counters with sync, active-video and per-frame commit strobe.
module vga_timing_gen
  import vga_sprite_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  output coord_t h,
  output coord_t v,
  output logic   hs,
  output logic   vs,
  output logic   active,
  output logic   commit
);

  localparam coord_t H_LAST     = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST     = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_ACT      = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT      = coord_t'(V_ACTIVE);
  localparam coord_t HS_START   = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END     = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START   = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END     = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  coord_t h_reg;
  coord_t v_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_reg <= '0;
      v_reg <= '0;
    end else if (h_reg == H_LAST) begin
      h_reg <= '0;
      v_reg <= (v_reg == V_LAST) ? '0 : v_reg + 1'b1;
    end else begin
      h_reg <= h_reg + 1'b1;
    end
  end

  assign h      = h_reg;
  assign v      = v_reg;
  assign hs     = !((h_reg >= HS_START) && (h_reg < HS_END));
  assign vs     = !((v_reg >= VS_START) && (v_reg < VS_END));
  assign active = (h_reg < H_ACT) && (v_reg < V_ACT);
  // First pixel of the first blank line: positions swap here so the visible image never tears.
  assign commit = (h_reg == '0) && (v_reg == V_ACT);

endmodule

// File: rtl/vga_sprite_compositor.sv
// Composites N_SPR fixed-priority ROM sprites over a background colour, 3-cycle pixel latency.
// Optional: define SPRITE_COLLISION_EN to add the per-frame oCOLLIDE bounding-box overlap report.
module vga_sprite_compositor
  import vga_sprite_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter int   N_SPR    = 4,
  parameter int   SPR_W    = 16,
  parameter int   SPR_H    = 16,
  parameter bgr_t KEY_BGR  = KEY_BGR_DEF,
  localparam int  CH_W     = (N_SPR > 1) ? $clog2(N_SPR) : 1,
  localparam int  ADDR_W   = $clog2(N_SPR * SPR_W * SPR_H)
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              iPOS_VALID,
  output logic              oPOS_READY,
  input  logic [CH_W-1:0]   iPOS_CH,
  input  logic [COORD_W-1:0] iPOS_X,
  input  logic [COORD_W-1:0] iPOS_Y,
  input  logic [BGR_W-1:0]  iBG_BGR,
  output logic [ADDR_W-1:0] oROM_ADDR,
  input  logic [BGR_W-1:0]  iROM_BGR,
  output logic              oFRAME,
  output logic              oBLANK_n,
  output logic              oHS,
  output logic              oVS,
  output logic [7:0]        b_data,
  output logic [7:0]        g_data,
  output logic [7:0]        r_data
`ifdef SPRITE_COLLISION_EN
  ,
  output logic [N_SPR-1:0]  oCOLLIDE
`endif
);

  localparam int    SX_W    = $clog2(SPR_W);
  localparam int    SY_W    = $clog2(SPR_H);
  localparam int    FULL_W  = CH_W + SY_W + SX_W;
  localparam diff_t SPR_W_D = diff_t'(SPR_W);
  localparam diff_t SPR_H_D = diff_t'(SPR_H);
  localparam pos_t  OFF_POS = '{x: coord_t'(H_ACTIVE), y: coord_t'(V_ACTIVE)};

  coord_t h;
  coord_t v;
  logic   hs;
  logic   vs;
  logic   active;
  logic   commit;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk    (iVGA_CLK),
    .rst_n  (iRST_n),
    .h      (h),
    .v      (v),
    .hs     (hs),
    .vs     (vs),
    .active (active),
    .commit (commit)
  );

  // Position port: always ready except on the commit cycle.
  logic ready_en_reg;
  logic pos_fire;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) ready_en_reg <= 1'b0;
    else         ready_en_reg <= 1'b1;
  end

  assign oPOS_READY = ready_en_reg & ~commit;
  assign pos_fire   = iPOS_VALID & oPOS_READY;
  assign oFRAME     = commit;

  pos_t             shadow_reg [N_SPR];
  pos_t             active_reg [N_SPR];
  diff_t            dx [N_SPR];
  diff_t            dy [N_SPR];
  logic [N_SPR-1:0] hit;

  for (genvar gi = 0; gi < N_SPR; gi++) begin : g_ch
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
        shadow_reg[gi] <= OFF_POS;
        active_reg[gi] <= OFF_POS;
      end else begin
        if (pos_fire && (iPOS_CH == CH_W'(gi)))
          shadow_reg[gi] <= '{x: iPOS_X, y: iPOS_Y};
        if (commit)
          active_reg[gi] <= shadow_reg[gi];
      end
    end

    assign dx[gi]  = coord_diff(h, active_reg[gi].x);
    assign dy[gi]  = coord_diff(v, active_reg[gi].y);
    // Gating with active video keeps off-screen positions from ever hitting during blanking.
    assign hit[gi] = active & (dx[gi] < SPR_W_D) & (dy[gi] < SPR_H_D);
  end

  logic            win_any;
  logic [CH_W-1:0] win_ch;
  logic [SX_W-1:0] win_dx;
  logic [SY_W-1:0] win_dy;
  logic [FULL_W-1:0] win_addr;

  // Scan from the highest channel down so the lowest hit channel is the last assignment.
  always_comb begin
    win_any = 1'b0;
    win_ch  = '0;
    win_dx  = '0;
    win_dy  = '0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_any = 1'b1;
        win_ch  = CH_W'(i);
        win_dx  = dx[i][SX_W-1:0];
        win_dy  = dy[i][SY_W-1:0];
      end
    end
  end

  assign win_addr = {win_ch, win_dy, win_dx};

  logic [ADDR_W-1:0] rom_addr_reg;
  logic              win_s1;
  logic              win_s2;
  logic [2:0]        hs_pipe;
  logic [2:0]        vs_pipe;
  logic [2:0]        blank_pipe;
  bgr_t              colour_reg;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rom_addr_reg <= '0;
      win_s1       <= 1'b0;
      win_s2       <= 1'b0;
      hs_pipe      <= 3'b111;
      vs_pipe      <= 3'b111;
      blank_pipe   <= 3'b000;
      colour_reg   <= '0;
    end else begin
      if (win_any)
        rom_addr_reg <= win_addr[ADDR_W-1:0];
      win_s1     <= win_any;
      win_s2     <= win_s1;
      hs_pipe    <= {hs_pipe[1:0], hs};
      vs_pipe    <= {vs_pipe[1:0], vs};
      blank_pipe <= {blank_pipe[1:0], active};
      if (!blank_pipe[1])
        colour_reg <= '0;
      else if (win_s2 && (iROM_BGR != KEY_BGR))
        colour_reg <= iROM_BGR;
      else
        colour_reg <= iBG_BGR;
    end
  end

  assign oROM_ADDR = rom_addr_reg;
  assign oHS       = hs_pipe[2];
  assign oVS       = vs_pipe[2];
  assign oBLANK_n  = blank_pipe[2];
  assign b_data    = colour_reg[23:16];
  assign g_data    = colour_reg[15:8];
  assign r_data    = colour_reg[7:0];

`ifdef SPRITE_COLLISION_EN
  logic [N_SPR-1:0] overlap;
  logic [N_SPR-1:0] sticky_reg;
  logic [N_SPR-1:0] collide_reg;

  for (genvar gi = 0; gi < N_SPR; gi++) begin : g_overlap
    assign overlap[gi] = hit[gi] & (|(hit & ~(N_SPR'(1) << gi)));
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sticky_reg  <= '0;
      collide_reg <= '0;
    end else if (commit) begin
      collide_reg <= sticky_reg;
      sticky_reg  <= '0;
    end else begin
      sticky_reg  <= sticky_reg | overlap;
    end
  end

  assign oCOLLIDE = collide_reg;
`endif

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Directed bench for vga_sprite_compositor on a reduced 64x46 raster (48x40 visible).
// Collision checks are compiled in when SPRITE_COLLISION_EN is defined.
module tb_vga_sprite_compositor;

  localparam int HT = 64;
  localparam int VT = 46;
  localparam int FR = HT * VT;
  localparam logic [23:0] BG = 24'h123456;

  logic        clk;
  logic        rst_n;
  logic        pos_valid;
  logic        pos_ready;
  logic [1:0]  pos_ch;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic [23:0] bg;
  logic [9:0]  rom_addr;
  logic [23:0] rom_q;
  logic        frame;
  logic        blank_n;
  logic        hs;
  logic        vs;
  logic [7:0]  b;
  logic [7:0]  g;
  logic [7:0]  r;
`ifdef SPRITE_COLLISION_EN
  logic [3:0]  collide;
`endif

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  logic [23:0] rom [0:1023];

  vga_sprite_compositor #(
    .H_ACTIVE (48), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_ACTIVE (40), .V_FP (2), .V_SYNC (2), .V_BP (2),
    .N_SPR (4), .SPR_W (16), .SPR_H (16), .KEY_BGR (24'hFF00FF)
  ) dut (
    .iVGA_CLK   (clk),
    .iRST_n     (rst_n),
    .iPOS_VALID (pos_valid),
    .oPOS_READY (pos_ready),
    .iPOS_CH    (pos_ch),
    .iPOS_X     (pos_x),
    .iPOS_Y     (pos_y),
    .iBG_BGR    (bg),
    .oROM_ADDR  (rom_addr),
    .iROM_BGR   (rom_q),
    .oFRAME     (frame),
    .oBLANK_n   (blank_n),
    .oHS        (hs),
    .oVS        (vs),
    .b_data     (b),
    .g_data     (g),
    .r_data     (r)
`ifdef SPRITE_COLLISION_EN
    ,
    .oCOLLIDE   (collide)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered sprite ROM: data follows the address by one clock.
  always @(posedge clk) rom_q <= rom[rom_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx(input int f, input int x, input int y);
    return f * FR + y * HT + x;
  endfunction

  // Waits until the beam counter index k is current; sampling happens on the falling edge.
  task automatic wait_idx(input int k);
    int guard = 0;
    while (edges < k && guard < 50000) begin
      @(negedge clk);
      guard++;
    end
    if (edges != k) check_val("wait_sync", edges, k);
  endtask

  task automatic pix(input string tag, input int f, input int x, input int y, input logic [23:0] exp);
    wait_idx(idx(f, x, y) + 3);
    check_val(tag, {b, g, r}, exp);
  endtask

  task automatic addr_at(input string tag, input int f, input int x, input int y, input int exp);
    wait_idx(idx(f, x, y) + 1);
    check_val(tag, rom_addr, exp);
  endtask

  task automatic pos_write(input int k, input int ch, input int x, input int y);
    wait_idx(k);
    pos_valid = 1'b1;
    pos_ch    = ch[1:0];
    pos_x     = x[9:0];
    pos_y     = y[9:0];
    check_val("ready_on_write", pos_ready, 1);
    wait_idx(k + 1);
    pos_valid = 1'b0;
    $display("write ch=%0d x=%0d y=%0d at cycle %0d", ch, x, y, k);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_hs"},    hs, 1);
    check_val({tag, "_vs"},    vs, 1);
    check_val({tag, "_blank"}, blank_n, 0);
    check_val({tag, "_rgb"},   {b, g, r}, 0);
    check_val({tag, "_frame"}, frame, 0);
    check_val({tag, "_addr"},  rom_addr, 0);
    check_val({tag, "_ready"}, pos_ready, 0);
`ifdef SPRITE_COLLISION_EN
    check_val({tag, "_collide"}, collide, 0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 24'hC00000 | 24'(i);
    rom[17]   = 24'hFF00FF;
    rst_n     = 1'b0;
    pos_valid = 1'b0;
    pos_ch    = '0;
    pos_x     = '0;
    pos_y     = '0;
    bg        = BG;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 0: background only, timing shape, staged write invisible until commit.
    wait_idx(1);
    check_val("ready_after_reset", pos_ready, 1);
    pix("bg_0_0", 0, 0, 0, BG);
    check_val("blank_0_0", blank_n, 1);
    pix("bg_47_0", 0, 47, 0, BG);
    pix("blank_rgb_48", 0, 48, 0, 24'h0);
    check_val("blank_48", blank_n, 0);
    wait_idx(idx(0, 51, 0) + 3); check_val("hs_h51", hs, 1);
    wait_idx(idx(0, 52, 0) + 3); check_val("hs_h52", hs, 0);
    wait_idx(idx(0, 59, 0) + 3); check_val("hs_h59", hs, 0);
    wait_idx(idx(0, 60, 0) + 3); check_val("hs_h60", hs, 1);
    pos_write(idx(0, 0, 10), 0, 20, 8);
    pix("precommit_20_20", 0, 20, 20, BG);
    pix("bg_47_39", 0, 47, 39, BG);
    pos_write(idx(0, 0, 40) - 1, 1, 20, 8);
    check_val("commit_frame", frame, 1);
    check_val("commit_ready", pos_ready, 0);
    wait_idx(idx(0, 0, 40) + 1);
    check_val("post_commit_frame", frame, 0);
    check_val("post_commit_ready", pos_ready, 1);
    wait_idx(idx(0, 0, 41) + 3); check_val("vs_v41", vs, 1);
    wait_idx(idx(0, 0, 42) + 3); check_val("vs_v42", vs, 0);
    wait_idx(idx(0, 0, 43) + 3); check_val("vs_v43", vs, 0);
    wait_idx(idx(0, 0, 44) + 3); check_val("vs_v44", vs, 1);

    // Frame 1: ch0 and ch1 overlap at (20,8); ch0 wins and its key pixel shows background.
    addr_at("addr_20_8", 1, 20, 8, 0);
    pix("left_edge_19_8", 1, 19, 8, BG);
    pix("spr_20_8", 1, 20, 8, 24'hC00000);
    pix("prio_22_8", 1, 22, 8, 24'hC00002);
    addr_at("addr_hold_36_8", 1, 36, 8, 15);
    pix("right_edge_36_8", 1, 36, 8, BG);
    pix("key_21_9", 1, 21, 9, BG);
    addr_at("addr_35_23", 1, 35, 23, 255);
    pix("spr_35_23", 1, 35, 23, 24'hC000FF);
    pos_write(idx(1, 0, 30), 2, 40, 30);
    pos_write(idx(1, 0, 31), 3, 48, 0);

    // Frame 2: right-edge clipping and hidden channel.
    pix("hidden_47_0", 2, 47, 0, BG);
    pix("clip_40_30", 2, 40, 30, 24'hC00200);
    addr_at("addr_47_30", 2, 47, 30, 519);
    pix("clip_47_30", 2, 47, 30, 24'hC00207);
    pix("clip_blank_50_30", 2, 50, 30, 24'h0);
    pix("nowrap_0_31", 2, 0, 31, BG);

    // Mid-frame reset.
    wait_idx(idx(2, 10, 33));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;

    pix("restart_0_0", 0, 0, 0, BG);
    check_val("restart_blank", blank_n, 1);
    pos_write(idx(0, 0, 10), 0, 2, 2);
    pos_write(idx(0, 0, 11), 3, 6, 6);
`ifdef SPRITE_COLLISION_EN
    wait_idx(idx(0, 0, 40) + 1);
    check_val("collide_f0", collide, 0);
`endif
    pix("spr_2_2", 1, 2, 2, 24'hC00000);
    pix("prio_6_6", 1, 6, 6, 24'hC00044);
    pix("cleared_34_22", 1, 34, 22, BG);
    pos_write(idx(1, 0, 35), 3, 30, 30);
`ifdef SPRITE_COLLISION_EN
    wait_idx(idx(1, 0, 40) + 1);
    check_val("collide_f1", collide, 4'b1001);
    wait_idx(idx(2, 0, 40) + 1);
    check_val("collide_f2", collide, 0);
`else
    wait_idx(idx(1, 0, 40));
    check_val("commit_frame_2", frame, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
